// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared pipeline-control constants and types
package pipe_ctrl_pkg;
  localparam int RA_W_DEF = 4;
  localparam int PC_REG_DEF = 15;
  localparam int STAGES_DEF = 3;
  typedef logic [RA_W_DEF-1:0] ra_t;
endpackage

// File: rtl/pc_write_tracker_if.sv
// pc_write_tracker_if: decode/hazard signals between control and the PC-write tracker
interface pc_write_tracker_if #(
  parameter int RA_W = 4,
  parameter int CNT_W = 8
);
  logic valid_d;
  logic [RA_W-1:0] rd_d;
  logic reg_w_d;
  logic branch_d;
  logic cond_ex_e;
  logic ldr_stall;
  logic stall_f;
  logic stall_d;
  logic flush_d;
  logic flush_e;
  logic branch_taken_e;
  logic pc_src_w;
  logic pc_wr_pending;
  logic [CNT_W-1:0] redirect_cnt;
  modport master (
    output valid_d, rd_d, reg_w_d, branch_d, cond_ex_e, ldr_stall,
    input stall_f, stall_d, flush_d, flush_e, branch_taken_e, pc_src_w, pc_wr_pending, redirect_cnt
  );
  modport slave (
    input valid_d, rd_d, reg_w_d, branch_d, cond_ex_e, ldr_stall,
    output stall_f, stall_d, flush_d, flush_e, branch_taken_e, pc_src_w, pc_wr_pending, redirect_cnt
  );
endinterface

// File: rtl/pc_write_tracker_pcs_gen.sv
// pcs_gen: combinational PC-source decode (write to the PC register or branch)
module pcs_gen #(
  parameter int RA_W = 4,
  parameter int PC_REG = 15
) (
  input  logic valid,
  input  logic [RA_W-1:0] rd,
  input  logic reg_w,
  input  logic branch,
  output logic pcs_reg,
  output logic br,
  output logic pcs
);
  // a real instruction writing the PC register, or a real branch
  always_comb begin
    pcs_reg = valid & reg_w & (rd == RA_W'(PC_REG));
    br = valid & branch;
    pcs = pcs_reg | br;
  end
endmodule

// File: rtl/pc_write_tracker.sv
// pc_write_tracker: tracks in-flight PC writes and derives stalls, flushes and PC select
module pc_write_tracker
  import pipe_ctrl_pkg::*;
#(
  parameter int RA_W = RA_W_DEF,
  parameter int PC_REG = PC_REG_DEF,
  parameter int STAGES = STAGES_DEF,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst_n,
  pc_write_tracker_if.slave bus
);
  logic pcs_reg_d, br_d, pcs_d;
  logic e_reg, e_br;
  logic bt, pw, mid, pend, fe;
  logic [STAGES-1:1] p;
  logic [CNT_W-1:0] cnt;
  pcs_gen #(.RA_W(RA_W), .PC_REG(PC_REG)) u_pcs (
    .valid(bus.valid_d),
    .rd(bus.rd_d),
    .reg_w(bus.reg_w_d),
    .branch(bus.branch_d),
    .pcs_reg(pcs_reg_d),
    .br(br_d),
    .pcs(pcs_d)
  );
  if (STAGES > 2) begin : g_mid
    assign mid = |p[STAGES-2:1];
  end else begin : g_no_mid
    assign mid = 1'b0;
  end
  // hazard equations; the writeback stage is excluded from pending
  always_comb begin
    bt = e_br & bus.cond_ex_e;
    pw = p[STAGES-1];
    pend = pcs_d | e_reg | e_br | mid;
    fe = bus.ldr_stall | bt;
  end
  assign bus.branch_taken_e = bt;
  assign bus.pc_src_w = pw;
  assign bus.pc_wr_pending = pend;
  assign bus.stall_f = bus.ldr_stall | pend;
  assign bus.stall_d = bus.ldr_stall;
  assign bus.flush_d = pend | pw | bt;
  assign bus.flush_e = fe;
  assign bus.redirect_cnt = cnt;
  // execute register takes a bubble whenever E is flushed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) {e_reg, e_br} <= 2'b00;
    else {e_reg, e_br} <= fe ? 2'b00 : {pcs_reg_d, br_d};
  end
  // PC writes that pass their condition ripple toward writeback
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) p <= '0;
    else begin
      p[1] <= e_reg & bus.cond_ex_e;
      for (int k = 2; k < STAGES; k++) p[k] <= p[k-1];
    end
  end
  // saturating redirect counter; coincident redirects count once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else if ((bt | pw) && cnt != '1) cnt <= cnt + 1'b1;
  end
endmodule
